// File: rtl/hidden_neuron_responder.sv
// Hidden-layer LIF neuron responder: accumulates weighted input spikes per neuron,
// integrates into a stored membrane voltage, fires on threshold and counts spikes.
module hidden_neuron_responder #(
    parameter int                       N_NEUR = 40,
    parameter int                       V_W    = 16,
    parameter int                       W_W    = 8,
    parameter logic signed [V_W-1:0]    THRESH = 16'sd256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [5:0]                  neuron_idx,
    input  logic                        vol_mem_control,
    input  logic signed [V_W-1:0]       init_mem_vol,
    input  logic                        load_voltage,
    input  logic                        w_n_a_valid,
    input  logic signed [W_W-1:0]       weight,
    input  logic                        act,
    input  logic                        arithm,
    input  logic                        export_voltage,
    input  logic                        current_step_finished,
    output logic                        spike_o,
    output logic [5:0]                  spike_idx_o,
    output logic                        spike_strobe,
    output logic [3*N_NEUR-1:0]         spike_cnt_vec,
    output logic                        result_valid,
    output logic                        proto_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WB, S_DONE} state_t;

    localparam logic [5:0]           N_NEUR_L = 6'(N_NEUR);
    localparam logic signed [V_W-1:0] V_MAX   = {1'b0, {(V_W-1){1'b1}}};
    localparam logic signed [V_W-1:0] V_MIN   = {1'b1, {(V_W-1){1'b0}}};

    function automatic logic signed [V_W-1:0] sat_add(input logic signed [V_W-1:0] a,
                                                      input logic signed [V_W-1:0] b);
        logic signed [V_W:0] s;
        s = {a[V_W-1], a} + {b[V_W-1], b};
        if (s[V_W] != s[V_W-1])
            return s[V_W] ? V_MIN : V_MAX;
        return s[V_W-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic signed [V_W-1:0]   cur_acc_q, cur_acc_d;
    logic signed [V_W-1:0]   v_reg_q, v_reg_d;
    logic [5:0]              idx_reg_q, idx_reg_d;
    logic                    spike_q, spike_d;
    logic [5:0]              spike_idx_q, spike_idx_d;
    logic                    spike_strobe_q, spike_strobe_d;
    logic                    result_valid_q, result_valid_d;
    logic                    proto_err_q, proto_err_d;
    logic [3*N_NEUR-1:0]     spike_cnt_q, spike_cnt_d;

    // Memories carry no reset; the controller's init sweep defines their contents.
    logic signed [V_W-1:0]   v_mem [N_NEUR];
    logic signed [V_W-1:0]   i_mem [N_NEUR];
    logic [2:0]              cnt_mem [N_NEUR];

    logic                    v_we, i_we, c_we;
    logic [5:0]              v_waddr, i_waddr, c_waddr;
    logic signed [V_W-1:0]   v_wdata, i_wdata;
    logic [2:0]              c_wdata;

    logic                    idx_ok;
    logic [5:0]              rd_idx;
    logic signed [V_W-1:0]   w_ext;
    logic signed [V_W-1:0]   v_new;
    logic signed [V_W-1:0]   v_fire;
    logic                    fire;
    logic [2:0]              cnt_cur;
    logic [3*N_NEUR-1:0]     cnt_flat;
    logic                    err_busy;

    assign idx_ok   = (neuron_idx < N_NEUR_L);
    assign rd_idx   = idx_ok ? neuron_idx : 6'd0;
    assign w_ext    = {{(V_W-W_W){weight[W_W-1]}}, weight};
    assign v_new    = sat_add(v_reg_q, cur_acc_q);
    assign fire     = (v_new >= THRESH);
    assign v_fire   = v_new - THRESH;
    assign cnt_cur  = cnt_mem[idx_reg_q];
    assign err_busy = load_voltage | vol_mem_control | current_step_finished;

    always_comb begin
        cnt_flat = '0;
        for (int k = 0; k < N_NEUR; k++)
            cnt_flat[3*k +: 3] = cnt_mem[k];
    end

    always_comb begin
        state_d        = state_q;
        cur_acc_d      = cur_acc_q;
        v_reg_d        = v_reg_q;
        idx_reg_d      = idx_reg_q;
        spike_d        = spike_q;
        spike_idx_d    = spike_idx_q;
        spike_strobe_d = 1'b0;
        result_valid_d = 1'b0;
        proto_err_d    = proto_err_q;
        spike_cnt_d    = spike_cnt_q;
        v_we           = 1'b0;
        v_waddr        = rd_idx;
        v_wdata        = init_mem_vol;
        i_we           = 1'b0;
        i_waddr        = rd_idx;
        i_wdata        = '0;
        c_we           = 1'b0;
        c_waddr        = rd_idx;
        c_wdata        = 3'd0;

        // Only the strobes that address memory through neuron_idx care about its range.
        if ((vol_mem_control || load_voltage) && !idx_ok)
            proto_err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (export_voltage)
                    proto_err_d = 1'b1;
                if (vol_mem_control) begin
                    if (load_voltage)
                        proto_err_d = 1'b1;
                    if (idx_ok) begin
                        v_we = 1'b1;
                        i_we = 1'b1;
                        c_we = 1'b1;
                    end
                end else if (load_voltage) begin
                    if (idx_ok) begin
                        v_reg_d   = v_mem[rd_idx];
                        cur_acc_d = arithm ? i_mem[rd_idx] : '0;
                        idx_reg_d = neuron_idx;
                        state_d   = S_ACC;
                    end
                end else if (current_step_finished) begin
                    state_d = S_DONE;
                end
            end
            S_ACC: begin
                if (err_busy)
                    proto_err_d = 1'b1;
                if (export_voltage) begin
                    if (!arithm) begin
                        i_we    = 1'b1;
                        i_waddr = idx_reg_q;
                        i_wdata = cur_acc_q;
                    end
                    state_d = S_WB;
                end else if (w_n_a_valid && !arithm && act) begin
                    cur_acc_d = sat_add(cur_acc_q, w_ext);
                end
            end
            S_WB: begin
                if (err_busy)
                    proto_err_d = 1'b1;
                v_we           = 1'b1;
                v_waddr        = idx_reg_q;
                v_wdata        = fire ? v_fire : v_new;
                c_we           = fire;
                c_waddr        = idx_reg_q;
                c_wdata        = (cnt_cur == 3'd7) ? 3'd7 : cnt_cur + 3'd1;
                spike_d        = fire;
                spike_idx_d    = idx_reg_q;
                spike_strobe_d = 1'b1;
                state_d        = S_IDLE;
            end
            S_DONE: begin
                if (err_busy)
                    proto_err_d = 1'b1;
                spike_cnt_d    = cnt_flat;
                result_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cur_acc_q      <= '0;
            v_reg_q        <= '0;
            idx_reg_q      <= '0;
            spike_q        <= 1'b0;
            spike_idx_q    <= '0;
            spike_strobe_q <= 1'b0;
            result_valid_q <= 1'b0;
            proto_err_q    <= 1'b0;
            spike_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            cur_acc_q      <= cur_acc_d;
            v_reg_q        <= v_reg_d;
            idx_reg_q      <= idx_reg_d;
            spike_q        <= spike_d;
            spike_idx_q    <= spike_idx_d;
            spike_strobe_q <= spike_strobe_d;
            result_valid_q <= result_valid_d;
            proto_err_q    <= proto_err_d;
            spike_cnt_q    <= spike_cnt_d;
        end
    end

    // Writes are suppressed while reset is held so an aborted update leaves memory intact.
    always_ff @(posedge clk) begin
        if (rst_n && v_we)
            v_mem[v_waddr] <= v_wdata;
        if (rst_n && i_we)
            i_mem[i_waddr] <= i_wdata;
        if (rst_n && c_we)
            cnt_mem[c_waddr] <= c_wdata;
    end

    assign spike_o       = spike_q;
    assign spike_idx_o   = spike_idx_q;
    assign spike_strobe  = spike_strobe_q;
    assign spike_cnt_vec = spike_cnt_q;
    assign result_valid  = result_valid_q;
    assign proto_err     = proto_err_q;

endmodule
